// File: rtl/mem_access_unit_pkg.sv
// Shared types and lane helpers for the data-memory access stage.
//   rvga_memsize   : access size encoding from the execute-side slicer
//   rvga_mau_state : access FSM states
//   lane_bit_shift : byte-lane offset to bit shift amount
//   is_misaligned  : natural-alignment check used when the misalign trap
//                    (RVGA_MISALIGN_TRAP_EN) is built in
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MEMSIZE_BYTE = 2'b00,
    MEMSIZE_HALF = 2'b01,
    MEMSIZE_WORD = 2'b10,
    MEMSIZE_RSVD = 2'b11
  } rvga_memsize;

  typedef enum logic [1:0] {
    MAU_IDLE = 2'b00,
    MAU_REQ  = 2'b01,
    MAU_RESP = 2'b10
  } rvga_mau_state;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  function automatic logic [4:0] lane_bit_shift(input logic [1:0] off);
    return {off, 3'b000};
  endfunction

  // The reserved size code behaves as a word access.
  function automatic logic is_misaligned(input rvga_memsize size, input logic [1:0] off);
    logic mis;
    case (size)
      MEMSIZE_BYTE: mis = 1'b0;
      MEMSIZE_HALF: mis = off[0];
      default:      mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_aligner.sv
// Combinational byte-lane alignment between the lane-0 slicer view and the
// word-addressed data bus.
//   offset     : byte offset addr[1:0]
//   st_data    : store data, lane 0 aligned   -> st_data_al : shifted up
//   st_mask    : store mask, lane 0 aligned   -> st_mask_al : shifted up
//   ld_raw     : bus read word                -> ld_data_al : shifted down
// Lanes pushed beyond lane 3 are dropped; nothing wraps into the next word.
module mem_access_unit_lane_aligner
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_mask,
  input  logic [31:0] ld_raw,
  output logic [31:0] st_data_al,
  output logic [3:0]  st_mask_al,
  output logic [31:0] ld_data_al
);

  assign st_data_al = st_data << lane_bit_shift(offset);
  assign st_mask_al = st_mask << offset;
  assign ld_data_al = ld_raw >> lane_bit_shift(offset);

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: accepts one lane-0 aligned load/store, drives a
// req/ack bus transaction with optional timeout, and returns load data
// shifted back to lane 0 with a one-cycle response pulse.
// Ports:
//   clk_i, reset_i (async, active high)
//   valid_i/ready_o, we_i, size_i, addr_i, wdata_i, wmask_i  : request side
//   resp_valid_o, ld_data_o, bus_err_o, misalign_o           : response side
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
//   mem_ack_i, mem_rdata_i                                   : data bus
// Build option: RVGA_MISALIGN_TRAP_EN turns misaligned requests into an
// immediate response with misalign_o=1 and no bus activity.
//
// state    | meaning
// IDLE     | ready for a request
// REQ      | bus request outstanding, timeout counter running
// RESP     | one-cycle response pulse
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wmask_i,
  output logic        resp_valid_o,
  output logic [31:0] ld_data_o,
  output logic        bus_err_o,
  output logic        misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wmask_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic             TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  rvga_mau_state state_q, state_d;

  logic              we_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wmask_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       ld_data_q;
  logic              bus_err_q;
  logic              misalign_q;

  logic              req_misalign;
  logic              timeout_hit;
  logic              in_req;
  logic [31:0]       st_data_al;
  logic [3:0]        st_mask_al;
  logic [31:0]       ld_data_al;

`ifdef RVGA_MISALIGN_TRAP_EN
  assign req_misalign = is_misaligned(rvga_memsize'(size_i), addr_i[1:0]);
`else
  // Size only matters to the misalign trap; without it, it is ignored.
  logic size_unused;
  assign size_unused  = ^size_i;
  assign req_misalign = 1'b0;
`endif

  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

  mem_access_unit_lane_aligner u_lane_aligner (
    .offset     (addr_q[1:0]),
    .st_data    (wdata_q),
    .st_mask    (wmask_q),
    .ld_raw     (mem_rdata_i),
    .st_data_al (st_data_al),
    .st_mask_al (st_mask_al),
    .ld_data_al (ld_data_al)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= MAU_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    ready_o      = 1'b0;
    in_req       = 1'b0;
    resp_valid_o = 1'b0;
    case (state_q)
      MAU_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_d = req_misalign ? MAU_RESP : MAU_REQ;
      end
      MAU_REQ: begin
        in_req = 1'b1;
        if (mem_ack_i || timeout_hit) state_d = MAU_RESP;
      end
      MAU_RESP: begin
        resp_valid_o = 1'b1;
        state_d      = MAU_IDLE;
      end
      default: state_d = MAU_IDLE;
    endcase
  end

  // Request capture, timeout counter and response registers. Result
  // registers are only non-zero while in RESP, so they feed the outputs
  // directly.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      cnt_q      <= '0;
      ld_data_q  <= '0;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        MAU_IDLE: begin
          if (valid_i) begin
            we_q       <= we_i;
            addr_q     <= addr_i;
            wdata_q    <= wdata_i;
            wmask_q    <= wmask_i;
            cnt_q      <= '0;
            ld_data_q  <= '0;
            bus_err_q  <= 1'b0;
            misalign_q <= req_misalign;
          end
        end
        MAU_REQ: begin
          // An ack on the terminal cycle takes priority over the timeout.
          if (mem_ack_i) begin
            ld_data_q <= we_q ? 32'h0 : ld_data_al;
            bus_err_q <= 1'b0;
          end else if (timeout_hit) begin
            ld_data_q <= '0;
            bus_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        MAU_RESP: begin
          ld_data_q  <= '0;
          bus_err_q  <= 1'b0;
          misalign_q <= 1'b0;
          cnt_q      <= '0;
        end
        default: ;
      endcase
    end
  end

  assign ld_data_o  = ld_data_q;
  assign bus_err_o  = bus_err_q;
  assign misalign_o = misalign_q;

  // Bus outputs are gated by REQ so they fall with the async reset.
  assign mem_req_o   = in_req;
  assign mem_we_o    = in_req & we_q;
  assign mem_addr_o  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata_o = in_req ? st_data_al : 32'h0;
  assign mem_wmask_o = in_req ? st_mask_al : 4'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int TIMEOUT = 16;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        we_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [3:0]  wmask_i = '0;
  logic        resp_valid_o;
  logic [31:0] ld_data_o;
  logic        bus_err_o;
  logic        misalign_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int errors = 0;
  int checks = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(5)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .valid_i(valid_i), .ready_o(ready_o), .we_i(we_i), .size_i(size_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .wmask_i(wmask_i),
    .resp_valid_o(resp_valid_o), .ld_data_o(ld_data_o),
    .bus_err_o(bus_err_o), .misalign_o(misalign_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: byte-granular view of the bus word.
  function automatic logic model_misalign(input logic [1:0] size, input logic [1:0] off);
`ifdef RVGA_MISALIGN_TRAP_EN
    if (size == 2'b00) return 1'b0;
    if (size == 2'b01) return (off == 2'd1) || (off == 2'd3);
    return off != 2'd0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        input int ack_delay, input logic [31:0] rdata, input logic late_ack);
    int off;
    logic [7:0] wb [4];
    logic [7:0] rb [4];
    logic [31:0] exp_addr, exp_wdata, exp_ld;
    logic [3:0] exp_mask;
    logic exp_mis, exp_err;
    int exp_cycles, k;
    bit done;

    off = int'(addr[1:0]);
    exp_addr = addr - 32'(off);
    exp_wdata = '0;
    exp_mask = '0;
    exp_ld = '0;
    for (int i = 0; i < 4; i++) begin
      wb[i] = wdata[8*i +: 8];
      rb[i] = rdata[8*i +: 8];
    end
    for (int i = 0; i < 4; i++) begin
      if (i + off < 4) begin
        exp_wdata[8*(i+off) +: 8] = wb[i];
        exp_mask[i+off] = wmask[i];
        exp_ld[8*i +: 8] = rb[i+off];
      end
    end
    exp_mis = model_misalign(size, addr[1:0]);
    if (exp_mis) begin
      exp_cycles = 0; exp_err = 1'b0; exp_ld = '0;
    end else if (ack_delay < TIMEOUT) begin
      exp_cycles = ack_delay + 1; exp_err = 1'b0;
      if (we) exp_ld = '0;
    end else begin
      exp_cycles = TIMEOUT; exp_err = 1'b1; exp_ld = '0;
    end

    check_val("ready_before", 32'(ready_o), 32'd1);
    valid_i = 1'b1; we_i = we; size_i = size; addr_i = addr;
    wdata_i = wdata; wmask_i = wmask; mem_rdata_i = rdata;
    @(negedge clk_i);
    valid_i = 1'b0;
    k = 0;
    done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (mem_req_o) begin
        if (k == 0) begin
          check_val("mem_addr", mem_addr_o, exp_addr);
          check_val("mem_wdata", mem_wdata_o, we ? exp_wdata : mem_wdata_o & 32'h0 | exp_wdata);
          check_val("mem_wmask", 32'(mem_wmask_o), 32'(exp_mask));
          check_val("mem_we", 32'(mem_we_o), 32'(we));
          check_val("ready_in_req", 32'(ready_o), 32'd0);
        end
        mem_ack_i = (k == ack_delay);
        k++;
      end else begin
        mem_ack_i = late_ack;
      end
      if (resp_valid_o) begin
        check_val("ld_data", ld_data_o, exp_ld);
        check_val("bus_err", 32'(bus_err_o), 32'(exp_err));
        check_val("misalign", 32'(misalign_o), 32'(exp_mis));
        check_val("req_cycles", 32'(k), 32'(exp_cycles));
        check_val("ready_in_resp", 32'(ready_o), 32'd0);
        done = 1;
      end
      @(negedge clk_i);
    end
    if (!done) check_val("resp_seen", 32'd0, 32'd1);
    check_val("resp_one_cycle", 32'(resp_valid_o), 32'd0);
    check_val("ready_after", 32'(ready_o), 32'd1);
    check_val("ld_idle", ld_data_o, 32'd0);
    check_val("req_idle", 32'(mem_req_o), 32'd0);
    mem_ack_i = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    check_val("rst_ready", 32'(ready_o), 32'd1);
    check_val("rst_req", 32'(mem_req_o), 32'd0);
    check_val("rst_resp", 32'(resp_valid_o), 32'd0);
    check_val("rst_addr", mem_addr_o, 32'd0);
    check_val("rst_ld", ld_data_o, 32'd0);
    reset_i = 1'b0;
    @(negedge clk_i);

    do_txn(1'b1, 2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 2, 32'h0, 1'b0);
    do_txn(1'b1, 2'b00, 32'h0000_0103, 32'h0000_00AB, 4'b0001, 0, 32'h0, 1'b0);
    do_txn(1'b0, 2'b01, 32'h0000_0102, 32'h0, 4'b0011, 1, 32'h8001_1234, 1'b0);
    do_txn(1'b0, 2'b10, 32'h0000_0200, 32'h0, 4'b1111, 99, 32'hFFFF_FFFF, 1'b1);
    do_txn(1'b0, 2'b10, 32'h0000_0101, 32'h0, 4'b1111, 0, 32'h1122_3344, 1'b0);
    do_txn(1'b0, 2'b10, 32'h0000_0300, 32'h0, 4'b1111, TIMEOUT - 1, 32'hCAFE_F00D, 1'b0);

    // Abort in REQ via reset.
    valid_i = 1'b1; we_i = 1'b0; size_i = 2'b10; addr_i = 32'h400;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_val("abort_req_before", 32'(mem_req_o), 32'd1);
    reset_i = 1'b1;
    #1;
    check_val("abort_req", 32'(mem_req_o), 32'd0);
    check_val("abort_ready", 32'(ready_o), 32'd1);
    @(negedge clk_i);
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_val("abort_no_resp", 32'(resp_valid_o), 32'd0);
    end

    for (int n = 0; n < 40; n++) begin
      do_txn(1'($urandom), 2'($urandom), $urandom, $urandom, 4'($urandom),
             int'($urandom_range(0, 20)), $urandom, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
